// File: rtl/ieeedrv_pkg.sv
// Shared types and helpers for the SD block-interface arbiter.
package ieeedrv_pkg;

    localparam int SD_BLK_W = 6;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ACKED,
        ABORT,
        RELEASE
    } arb_state_t;

    // Request parameters captured at grant time so requester changes are ignored
    typedef struct packed {
        logic [31:0]         lba;
        logic [SD_BLK_W-1:0] blk_cnt;
        logic                wr;
    } sd_req_t;

    // Index `off` positions after `base`, wrapped into 0..n-1
    function automatic int rr_wrap(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/ieeedrv_rr_pick.sv
// Round-robin picker: first pending requester strictly after `last`, wrapping.
module ieeedrv_rr_pick
    import ieeedrv_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] pending,
    input  logic [IW-1:0]   last,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    logic [IW-1:0] cand;

    // Scan from farthest to nearest so the nearest pending index after `last` wins
    always_comb begin
        valid = |pending;
        idx   = '0;
        cand  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IW'(rr_wrap(int'(last), k, NREQ));
            if (pending[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/ieeedrv_sd_arb.sv
// Shares one MiSTer SD block interface between NREQ requesters with
// round-robin grants, full rd/wr/ack sequencing and a no-ack timeout.
module ieeedrv_sd_arb
    import ieeedrv_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int TMO_W = 24
) (
    input  logic                           clk_sys,
    input  logic                           reset,
    input  logic [NREQ-1:0][31:0]          req_lba,
    input  logic [NREQ-1:0][SD_BLK_W-1:0]  req_blk_cnt,
    input  logic [NREQ-1:0]                req_rd,
    input  logic [NREQ-1:0]                req_wr,
    output logic [NREQ-1:0]                req_ack,
    output logic [NREQ-1:0]                req_err,
    input  logic [NREQ-1:0][7:0]           req_buff_din,
    output logic [NREQ-1:0]                req_buff_wr,
    output logic [31:0]                    sd_lba,
    output logic [SD_BLK_W-1:0]            sd_blk_cnt,
    output logic                           sd_rd,
    output logic                           sd_wr,
    input  logic                           sd_ack,
    input  logic                           sd_buff_wr,
    output logic [7:0]                     sd_buff_din,
    output logic                           busy
);

    localparam int IW = $clog2(NREQ);
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    arb_state_t      state;
    logic [IW-1:0]   grant;
    logic [IW-1:0]   last;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;
    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] lvl;
    logic [NREQ-1:0] lvl_prev;
    sd_req_t         latched;
    logic            req_on;
    logic [TMO_W-1:0] tmo_cnt;
    logic            route;

    assign lvl = req_rd | req_wr;

    ieeedrv_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .pending (pending),
        .last    (last),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    // Host strobes come from the latched direction so they can never overlap
    assign sd_rd      = req_on & ~latched.wr;
    assign sd_wr      = req_on &  latched.wr;
    assign sd_lba     = latched.lba;
    assign sd_blk_cnt = latched.blk_cnt;

    // The ack is forwarded from the cycle the host first raises it until it drops
    assign route = (state == ACKED) || ((state == REQ) && sd_ack);

    // Gate ack and buffer strobes to the granted requester only
    always_comb begin
        req_ack     = '0;
        req_buff_wr = '0;
        if (route) begin
            req_ack[grant]     = sd_ack;
            req_buff_wr[grant] = sd_buff_wr;
        end
    end

    // Write data to host follows the granted requester; quiet while idle
    always_comb begin
        sd_buff_din = 8'h00;
        if (state != IDLE) begin
            sd_buff_din = req_buff_din[grant];
        end
    end

    // Capture new requests; the granted requester is frozen until it is released
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            pending  <= '0;
            lvl_prev <= '0;
        end else begin
            lvl_prev <= lvl;
            for (int i = 0; i < NREQ; i++) begin
                if ((state != IDLE) && (grant == IW'(i))) begin
                    if (((state == REQ) && sd_ack) || (state == ABORT)) begin
                        pending[i] <= 1'b0;
                    end
                end else if (lvl[i] && (!lvl_prev[i] || (state == IDLE))) begin
                    pending[i] <= 1'b1;
                end
            end
        end
    end

    // Grant sequencing: pick, hold strobe until ack or timeout, wait ack low, release
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= '0;
            last    <= IW'(NREQ - 1);
            latched <= '0;
            req_on  <= 1'b0;
            req_err <= '0;
            busy    <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            req_err <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant           <= pick_idx;
                        latched.lba     <= req_lba[pick_idx];
                        latched.blk_cnt <= req_blk_cnt[pick_idx];
                        latched.wr      <= req_wr[pick_idx];
                        req_on          <= 1'b1;
                        tmo_cnt         <= '0;
                        busy            <= 1'b1;
                        state           <= REQ;
                    end
                end
                REQ: begin
                    if (sd_ack) begin
                        req_on <= 1'b0;
                        state  <= ACKED;
                    end else if (tmo_cnt == TMO_LAST) begin
                        req_on         <= 1'b0;
                        req_err[grant] <= 1'b1;
                        tmo_cnt        <= tmo_cnt + 1'b1;
                        state          <= ABORT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ACKED: begin
                    if (!sd_ack) begin
                        state <= RELEASE;
                    end
                end
                ABORT: begin
                    state <= RELEASE;
                end
                RELEASE: begin
                    last  <= grant;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
